// File: rtl/ipdc_pkg.sv
// Shared constants and FSM encoding for the ipdc host and the ipdc core.
// Sizes here fix every port width of the host.
package ipdc_pkg;

  localparam int IMG_PIXELS  = 64;
  localparam int DISP_PIXELS = 16;
  localparam int WDOG_MAX    = 255;

  localparam logic [2:0] OP_LOAD = 3'd0;

  localparam int MODE_W = 3;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 24;
  localparam int IDX_W  = 4;
  localparam int WDOG_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    LOAD,
    COLLECT,
    WAIT_RDY
  } state_e;

endpackage

// File: rtl/ipdc_host_if.sv
// Host <-> ipdc signal bundle; master is the host side.
// Clock and reset stay outside the bundle.
interface ipdc_host_if;
  import ipdc_pkg::*;

  logic              cmd_valid;
  logic [MODE_W-1:0] cmd_mode;
  logic              cmd_ready;
  logic [ADDR_W-1:0] pix_addr;
  logic [DATA_W-1:0] pix_data;
  logic              op_valid;
  logic [MODE_W-1:0] op_mode;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [IDX_W-1:0]  res_idx;
  logic              done;
  logic              err;

  modport master (
    input  cmd_valid, cmd_mode, pix_data,
    input  in_ready, out_valid, out_data,
    output cmd_ready, pix_addr, op_valid, op_mode,
    output in_valid, in_data, res_valid,
    output res_data, res_idx, done, err
  );

  modport slave (
    output cmd_valid, cmd_mode, pix_data,
    output in_ready, out_valid, out_data,
    input  cmd_ready, pix_addr, op_valid, op_mode,
    input  in_valid, in_data, res_valid,
    input  res_data, res_idx, done, err
  );

endinterface

// File: rtl/ipdc_host.sv
// Host sequencer for the ipdc: issues ops, streams a 64-pixel image,
// and captures the 16-beat display result with a watchdog.
module ipdc_host
  import ipdc_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  input  logic [MODE_W-1:0] i_cmd_mode,
  output logic              o_cmd_ready,
  output logic [ADDR_W-1:0] o_pix_addr,
  input  logic [DATA_W-1:0] i_pix_data,
  output logic              o_op_valid,
  output logic [MODE_W-1:0] o_op_mode,
  output logic              o_in_valid,
  output logic [DATA_W-1:0] o_in_data,
  input  logic              i_in_ready,
  input  logic              i_out_valid,
  input  logic [DATA_W-1:0] i_out_data,
  output logic              o_res_valid,
  output logic [DATA_W-1:0] o_res_data,
  output logic [IDX_W-1:0]  o_res_idx,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] PIX_LAST  = ADDR_W'(IMG_PIXELS - 1);
  localparam logic [IDX_W-1:0]  BEAT_LAST = IDX_W'(DISP_PIXELS - 1);
  localparam logic [WDOG_W-1:0] WDOG_TOP  = WDOG_W'(WDOG_MAX);

  state_e state, nxt;

  logic              addr_done;
  logic              rd_v;
  logic              rd_last;
  logic              in_last;
  logic [IDX_W-1:0]  beat_cnt;
  logic [WDOG_W-1:0] wdog;

  logic              accept;
  logic              issue;
  logic              beat;
  logic              last_beat;
  logic [WDOG_W-1:0] wdog_nxt;
  logic              wdog_hit;

  assign o_cmd_ready = (state == IDLE) && i_in_ready;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign issue       = (state == LOAD) && !addr_done;
  assign beat        = (state == COLLECT) && i_out_valid;
  assign last_beat   = beat && (beat_cnt == BEAT_LAST);
  assign wdog_nxt    = wdog + 1'b1;
  assign wdog_hit    = (state == COLLECT) && !i_out_valid
                    && (wdog_nxt == WDOG_TOP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (accept) nxt = ISSUE;
      ISSUE:    nxt = (o_op_mode == OP_LOAD) ? LOAD : COLLECT;
      LOAD:     if (in_last) nxt = WAIT_RDY;
      COLLECT:  if (last_beat || wdog_hit) nxt = WAIT_RDY;
      WAIT_RDY: if (i_in_ready) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Address k is read back one cycle later, then registered onto o_in_data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_op_valid  <= 1'b0;
      o_op_mode   <= '0;
      o_pix_addr  <= '0;
      addr_done   <= 1'b0;
      rd_v        <= 1'b0;
      rd_last     <= 1'b0;
      in_last     <= 1'b0;
      o_in_valid  <= 1'b0;
      o_in_data   <= '0;
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
      o_res_idx   <= '0;
      beat_cnt    <= '0;
      wdog        <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_op_valid <= (nxt == ISSUE);
      if (accept) o_op_mode <= i_cmd_mode;

      if (state == ISSUE) begin
        o_pix_addr <= '0;
        addr_done  <= 1'b0;
        beat_cnt   <= '0;
        wdog       <= '0;
      end

      if (issue) begin
        if (o_pix_addr == PIX_LAST) addr_done <= 1'b1;
        else                        o_pix_addr <= o_pix_addr + 1'b1;
      end
      rd_v       <= issue;
      rd_last    <= issue && (o_pix_addr == PIX_LAST);
      o_in_valid <= rd_v;
      in_last    <= rd_last;
      if (rd_v) o_in_data <= i_pix_data;

      o_res_valid <= beat;
      if (beat) begin
        o_res_data <= i_out_data;
        o_res_idx  <= beat_cnt;
        wdog       <= '0;
        if (beat_cnt != BEAT_LAST) beat_cnt <= beat_cnt + 1'b1;
      end else if (state == COLLECT) begin
        wdog <= wdog_nxt;
      end

      if (wdog_hit) o_err <= 1'b1;
      o_done <= (state == WAIT_RDY) && i_in_ready;
    end
  end

endmodule

// File: tb/tb_ipdc_host.sv
// Directed bench for ipdc_host: load, display, busy, timeout, reset abort.
// A registered pixel source and a scripted ipdc model drive the host.
module tb_ipdc_host;
  import ipdc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ipdc_host_if bus();

  ipdc_host dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cmd_valid (bus.cmd_valid),
    .i_cmd_mode  (bus.cmd_mode),
    .o_cmd_ready (bus.cmd_ready),
    .o_pix_addr  (bus.pix_addr),
    .i_pix_data  (bus.pix_data),
    .o_op_valid  (bus.op_valid),
    .o_op_mode   (bus.op_mode),
    .o_in_valid  (bus.in_valid),
    .o_in_data   (bus.in_data),
    .i_in_ready  (bus.in_ready),
    .i_out_valid (bus.out_valid),
    .i_out_data  (bus.out_data),
    .o_res_valid (bus.res_valid),
    .o_res_data  (bus.res_data),
    .o_res_idx   (bus.res_idx),
    .o_done      (bus.done),
    .o_err       (bus.err)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pat(input logic [5:0] a);
    return {2'b00, a, 2'b00, a, 2'b00, a};
  endfunction

  always @(posedge clk) bus.pix_data <= pat(bus.pix_addr);

  int          cyc = 0;
  logic [23:0] in_q[$];
  int          in_cyc[$];
  logic [27:0] res_q[$];
  int          res_cyc[$];
  int          out_cyc[$];
  int          op_cnt, done_cnt, lat_bad, op_cyc, err_cyc;
  logic [2:0]  op_mode_seen;
  logic [5:0]  a1, a2;
  bit          collecting = 1'b0;

  initial begin
    a1 = '0;
    a2 = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.in_valid === 1'b1) begin
        in_q.push_back(bus.in_data);
        in_cyc.push_back(cyc);
        if (bus.in_data !== pat(a2)) lat_bad++;
      end
      a2 = a1;
      a1 = bus.pix_addr;
      if (bus.res_valid === 1'b1) begin
        res_q.push_back({bus.res_idx, bus.res_data});
        res_cyc.push_back(cyc);
      end
      if (collecting && bus.out_valid) out_cyc.push_back(cyc);
      if (bus.op_valid === 1'b1) begin
        op_cnt++;
        op_mode_seen = bus.op_mode;
        op_cyc = cyc;
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.err === 1'b1 && err_cyc < 0) err_cyc = cyc;
    end
  end

  task automatic clr();
    in_q.delete();
    in_cyc.delete();
    res_q.delete();
    res_cyc.delete();
    out_cyc.delete();
    op_cnt = 0;
    done_cnt = 0;
    lat_bad = 0;
    op_cyc = 0;
    err_cyc = -1;
    op_mode_seen = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (done_cnt == 0 && i < budget) begin
      tick(1);
      i++;
    end
    chk(tag, 32'(done_cnt), 32'd1);
  endtask

  task automatic send(input logic [2:0] m);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = m;
    tick(1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic chk_load(input string tag);
    chk({tag, "_beats"}, 32'(in_q.size()), 32'd64);
    chk({tag, "_lat"}, 32'(lat_bad), 32'd0);
    if (in_q.size() == 64) begin
      chk({tag, "_gapless"}, 32'(in_cyc[63] - in_cyc[0]), 32'd63);
      chk({tag, "_first_lat"}, 32'(in_cyc[0] - op_cyc), 32'd3);
      for (int k = 0; k < 64; k++)
        chk($sformatf("%s_px%0d", tag, k), 32'(in_q[k]),
            32'(k * 32'h010101));
    end
  endtask

  initial begin
    int busy;
    int i;
    clr();
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = '0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    tick(2);

    chk("rst_flags", 32'({bus.op_valid, bus.in_valid, bus.res_valid,
                          bus.done, bus.err}), 32'd0);
    chk("rst_addr", 32'(bus.pix_addr), 32'd0);
    chk("rst_in_data", 32'(bus.in_data), 32'd0);
    chk("rst_res", 32'({bus.res_idx, bus.res_data}), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);

    rst_n = 1'b1;
    bus.in_ready = 1'b1;
    #1;
    chk("idle_ready", 32'(bus.cmd_ready), 32'd1);

    // command held while the ipdc is not ready
    bus.in_ready  = 1'b0;
    bus.cmd_valid = 1'b1;
    tick(3);
    chk("wait_ready_low", 32'(bus.cmd_ready), 32'd0);
    chk("wait_no_op", 32'(op_cnt), 32'd0);

    // stray ipdc output while idle
    bus.cmd_valid = 1'b0;
    bus.in_ready  = 1'b1;
    bus.out_valid = 1'b1;
    bus.out_data  = 24'h123456;
    tick(2);
    bus.out_valid = 1'b0;
    tick(2);
    chk("stray_res", 32'(res_q.size()), 32'd0);

    // load with a second command held during the stream
    clr();
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 3'd0;
    tick(1);
    bus.in_ready = 1'b0;
    busy = 0;
    for (int k = 0; k < 100; k++) begin
      tick(1);
      if (bus.cmd_ready) busy++;
    end
    chk("load_done_early", 32'(done_cnt), 32'd0);
    chk("load_busy_ready", 32'(busy), 32'd0);
    bus.cmd_valid = 1'b0;
    bus.in_ready  = 1'b1;
    wait_done("load_done", 20);
    tick(3);
    chk("load_op_cnt", 32'(op_cnt), 32'd1);
    chk("load_op_mode", 32'(op_mode_seen), 32'd0);
    chk("load_done_cnt", 32'(done_cnt), 32'd1);
    chk_load("load");

    // display: 16 beats with a gap after beat 7
    clr();
    send(3'd1);
    tick(2);
    collecting = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.out_valid = 1'b1;
      bus.out_data  = 24'hA00000 + 24'(k);
      tick(1);
      if (k == 7) begin
        bus.out_valid = 1'b0;
        tick(3);
      end
    end
    bus.out_valid = 1'b0;
    collecting = 1'b0;
    wait_done("disp_done", 10);
    chk("disp_op_mode", 32'(op_mode_seen), 32'd1);
    chk("disp_err", 32'(bus.err), 32'd0);
    chk("disp_beats", 32'(res_q.size()), 32'd16);
    if (res_q.size() == 16 && out_cyc.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("disp_idx%0d", k), 32'(res_q[k][27:24]), 32'(k));
        chk($sformatf("disp_data%0d", k), 32'(res_q[k][23:0]),
            32'h00A00000 + 32'(k));
        chk($sformatf("disp_lag%0d", k),
            32'(res_cyc[k] - out_cyc[k]), 32'd1);
      end
    end

    // timeout with a silent ipdc
    clr();
    send(3'd2);
    wait_done("to_done", 400);
    chk("to_op_mode", 32'(op_mode_seen), 32'd2);
    chk("to_err_lat", 32'(err_cyc - op_cyc), 32'd256);
    tick(10);
    chk("to_err_sticky", 32'(bus.err), 32'd1);
    chk("to_no_res", 32'(res_q.size()), 32'd0);
    chk("to_done_cnt", 32'(done_cnt), 32'd1);

    // reset while pixel 30 is on the stream
    clr();
    send(3'd0);
    i = 0;
    while (!(in_q.size() > 0 && in_q[$] == pat(6'd30)) && i < 100) begin
      tick(1);
      i++;
    end
    chk("rst_at_px30", 32'(in_q.size()), 32'd31);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_flags", 32'({bus.op_valid, bus.in_valid, bus.res_valid,
                              bus.done, bus.err}), 32'd0);
    chk("mid_rst_addr", 32'(bus.pix_addr), 32'd0);
    chk("mid_rst_data", 32'({bus.op_mode, bus.in_data}), 32'd0);
    chk("mid_rst_idle", 32'(bus.cmd_ready), 32'd1);
    tick(3);
    rst_n = 1'b1;
    tick(80);
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);

    clr();
    send(3'd0);
    wait_done("reload_done", 150);
    chk_load("reload");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
